lsu_multi: RTL and testbench
============================

Name: lsu_multi

Overview:
- Load/store unit for the ARMv4T core. It replaces the single-beat inline load/store path.
- Executes LDR/STR (byte/half/word, signed/unsigned) and LDM/STM multi-register transfers over the core's memory handshake (mem_ok).
- Sits between the execute stage, the register file and the memory bus.
- Adds proper sign extension, ARM misaligned-word rotation, parametrised register-list transfers and a bus-wait timeout.

Parameters:
- NREGS, 16, number of registers addressable by req_regmask; index width is clog2(NREGS).
- ADDR_W, 32, address width.
- WAIT_MAX, 255, max consecutive wait cycles per beat before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- req_load  in  1  1=load, 0=store
- req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- req_signed  in  1  sign-extend loads (byte/half only)
- req_multi  in  1  multi-register transfer; forces word size
- req_regmask  in  NREGS  registers to transfer; single transfer uses the lowest set bit
- req_addr  in  ADDR_W  start (lowest) address
- rf_raddr  out  clog2(NREGS)  store source register index
- rf_rdata  in  32  combinational register read data
- rf_we  out  1  load writeback strobe
- rf_waddr  out  clog2(NREGS)  writeback index
- rf_wdata  out  32  writeback data
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  32  bus store data; low bytes are significant per width
- mem_rdata  in  32  bus load data, right-justified for byte/half, aligned word for word
- mem_width  out  2  transfer width, same encoding as req_size
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_ok  in  1  beat complete when high at a rising edge
- done  out  1  one-cycle completion pulse
- done_err  out  1  valid with done; 1 = timeout abort
- done_addr  out  ADDR_W  address after the last completed beat (base writeback)
- done_count  out  clog2(NREGS)+1  beats completed

Behaviour:
- Reset (rstn low at an edge):
  - State goes to IDLE. All internal state clears.
  - Outputs: mem_read=0, mem_write=0, rf_we=0, done=0, done_err=0, req_ready=1; addr/data outputs 0.
  - Reset mid-transfer abandons the transfer silently, with no done pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req_valid & req_ready latches all req_* fields.
  - Empty mask goes to DONE (done_count=0, done_addr=req_addr, no bus activity). Otherwise go to ACCESS.
- ACCESS:
  - Outputs are registered and held stable until mem_ok.
  - Current register = lowest remaining set bit of the latched mask.
  - mem_read = load, mem_write = ~load.
  - On mem_ok: clear that bit, advance the address and increment the beat count.
  - If bits remain, issue the next beat in the following cycle with strobes continuously asserted. Throughput is 1 beat/cycle when mem_ok is held high.
  - When the mask is exhausted, go to DONE.
- Addressing:
  - Word/multi: mem_addr = addr & ~3.
  - Half: mem_addr = addr & ~1.
  - Byte: mem_addr = addr.
  - Multi increments by 4 per beat, in ascending register order. A single transfer performs exactly one beat.
  - done_addr = latched addr + 4*done_count for multi; latched addr for single.
- Loads:
  - rf_we = ACCESS & load & mem_ok (combinational), with rf_waddr = current register.
  - Word: rf_wdata = mem_rdata rotated right by 8*addr[1:0]. Multi uses no rotation.
  - Byte/half: zero-extend, or sign-extend when req_signed.
- Stores:
  - rf_raddr = current register.
  - mem_wdata = rf_rdata (combinational), so it tracks the register for the whole beat.
- Timeout:
  - The wait counter resets on each new beat and counts ACCESS cycles with mem_ok low.
  - When the counter reaches WAIT_MAX, the beat is abandoned: strobes drop the next cycle and the FSM goes to DONE with done_err=1. done_count/done_addr reflect the completed beats only.
- DONE:
  - done=1 for one cycle, strobes 0, then IDLE.
  - req_ready=1 again the cycle after DONE.
  - Requests arriving while not ready are ignored.

Test Plan:
- Single word load at 0x08000002 with mem_rdata=0xAABBCCDD and mem_ok immediate -> mem_addr=0x08000000, rf_wdata=0xCCDDAABB; done pulses 2 cycles after accept.
- Signed byte load at 0x03000001 with rdata=0x00000080 -> rf_wdata=0xFFFFFF80. Unsigned half with rdata=0x8001 -> 0x00008001. Signed half with the same rdata -> 0xFFFF8001.
- LDM with mask 0x000B at 0x03000010, mem_ok held high -> beats 0x10/0x14/0x18 on consecutive cycles; rf_waddr 0,1,3; done_count=3; done_addr=0x0300001C.
- STM with mask 0x0006 and mem_ok delayed 2 cycles per beat -> mem_addr and mem_write stable while waiting; mem_wdata = r1 then r2; done_err=0.
- WAIT_MAX=4, LDM with mask 0x0003, mem_ok high for beat 1 then never -> done_err=1, done_count=1, done_addr=base+4, no second rf_we.
- rstn low during the second LDM beat -> next cycle mem_read=0, no done pulse; req_ready=1 once rstn releases.

Source files
------------

// File: rtl/lsu_multi_if.sv
// Load/store unit bundle: request channel, register-file ports, memory bus and completion.
// The master modport is the LSU side; the slave modport is the core/memory environment.
interface lsu_multi_if #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned IDX_W = $clog2(NREGS);
    localparam int unsigned CNT_W = IDX_W + 1;

    // request from execute
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              req_multi;
    logic [NREGS-1:0]  req_regmask;
    logic [ADDR_W-1:0] req_addr;

    // register file
    logic [IDX_W-1:0]  rf_raddr;
    logic [31:0]       rf_rdata;
    logic              rf_we;
    logic [IDX_W-1:0]  rf_waddr;
    logic [31:0]       rf_wdata;

    // memory bus
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [1:0]        mem_width;
    logic              mem_read;
    logic              mem_write;
    logic              mem_ok;

    // completion
    logic              done;
    logic              done_err;
    logic [ADDR_W-1:0] done_addr;
    logic [CNT_W-1:0]  done_count;

    modport master (
        input  req_valid, req_load, req_size, req_signed, req_multi, req_regmask, req_addr,
        input  rf_rdata, mem_rdata, mem_ok,
        output req_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
        output mem_addr, mem_wdata, mem_width, mem_read, mem_write,
        output done, done_err, done_addr, done_count
    );

    modport slave (
        output req_valid, req_load, req_size, req_signed, req_multi, req_regmask, req_addr,
        output rf_rdata, mem_rdata, mem_ok,
        input  req_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
        input  mem_addr, mem_wdata, mem_width, mem_read, mem_write,
        input  done, done_err, done_addr, done_count
    );
endinterface

// File: rtl/lsu_multi.sv
// Load/store unit: single LDR/STR (byte/half/word, signed/unsigned) and LDM/STM register-list
// transfers over the mem_ok handshake, with ARM word rotation and a per-beat wait timeout.
module lsu_multi #(
    parameter int unsigned NREGS    = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic          clk,
    input  logic          rstn,
    lsu_multi_if.master   bus
);
    localparam int unsigned IDX_W  = $clog2(NREGS);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_n;

    // latched request and per-beat progress
    logic              load_q, load_n;
    logic              signed_q, signed_n;
    logic              multi_q, multi_n;
    logic [1:0]        size_q, size_n;
    logic [NREGS-1:0]  mask_q, mask_n;
    logic [IDX_W-1:0]  cur_q, cur_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [WAIT_W-1:0] wait_q, wait_n;

    // registered outputs
    logic              ready_q, ready_n;
    logic              rd_q, rd_n;
    logic              wr_q, wr_n;
    logic [ADDR_W-1:0] maddr_q, maddr_n;
    logic [1:0]        width_q, width_n;
    logic              done_q, done_n;
    logic              derr_q, derr_n;
    logic [ADDR_W-1:0] daddr_q, daddr_n;
    logic [CNT_W-1:0]  dcnt_q, dcnt_n;

    logic              accept;
    logic              beat_ok;
    logic              timeout;
    logic [NREGS-1:0]  rem_mask;
    logic [5:0]        rot_sh;
    logic [31:0]       rot_word;
    logic [31:0]       load_data;

    // index of the lowest set bit (0 when empty)
    function automatic logic [IDX_W-1:0] lowest(input logic [NREGS-1:0] m);
        lowest = '0;
        for (int i = int'(NREGS) - 1; i >= 0; i--) begin
            if (m[i]) lowest = IDX_W'(i);
        end
    endfunction

    // bus address alignment for the transfer width
    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        unique case (sz)
            SZ_BYTE: align = a;
            SZ_HALF: align = a & ~ADDR_W'(1);
            default: align = a & ~ADDR_W'(3);
        endcase
    endfunction

    assign accept   = (state_q == IDLE) && bus.req_valid;
    assign beat_ok  = (state_q == ACCESS) && bus.mem_ok;
    assign timeout  = (state_q == ACCESS) && !bus.mem_ok && (WAIT_MAX != 0)
                      && (wait_q == WAIT_W'(WAIT_MAX - 1));
    assign rem_mask = mask_q & ~(NREGS'(1) << cur_q);

    // state register
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_n = (bus.req_regmask == '0) ? DONE : ACCESS;
            end
            ACCESS: begin
                if (beat_ok) begin
                    if (rem_mask == '0) state_n = DONE;
                end else if (timeout) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // datapath updates and next values of the registered outputs
    always_comb begin
        load_n   = load_q;
        signed_n = signed_q;
        multi_n  = multi_q;
        size_n   = size_q;
        mask_n   = mask_q;
        cur_n    = cur_q;
        addr_n   = addr_q;
        cnt_n    = cnt_q;
        wait_n   = wait_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load_n   = bus.req_load;
                    signed_n = bus.req_signed;
                    multi_n  = bus.req_multi;
                    size_n   = (bus.req_multi || bus.req_size == 2'd3) ? SZ_WORD : bus.req_size;
                    // a single transfer keeps only the lowest requested register
                    mask_n   = bus.req_multi ? bus.req_regmask
                                             : (bus.req_regmask & (~bus.req_regmask + NREGS'(1)));
                    cur_n    = lowest(bus.req_regmask);
                    addr_n   = bus.req_addr;
                    cnt_n    = '0;
                    wait_n   = '0;
                end
            end
            ACCESS: begin
                if (beat_ok) begin
                    mask_n = rem_mask;
                    cur_n  = lowest(rem_mask);
                    cnt_n  = cnt_q + CNT_W'(1);
                    wait_n = '0;
                    if (multi_q) addr_n = addr_q + ADDR_W'(4);
                end else begin
                    wait_n = wait_q + WAIT_W'(1);
                end
            end
            default: ;
        endcase

        ready_n = (state_n == IDLE);
        rd_n    = (state_n == ACCESS) && load_n;
        wr_n    = (state_n == ACCESS) && !load_n;
        maddr_n = align(addr_n, size_n);
        width_n = size_n;
        done_n  = (state_n == DONE);
        derr_n  = timeout;
        daddr_n = addr_n;
        dcnt_n  = cnt_n;
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            load_q   <= 1'b0;
            signed_q <= 1'b0;
            multi_q  <= 1'b0;
            size_q   <= '0;
            mask_q   <= '0;
            cur_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            ready_q  <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            maddr_q  <= '0;
            width_q  <= '0;
            done_q   <= 1'b0;
            derr_q   <= 1'b0;
            daddr_q  <= '0;
            dcnt_q   <= '0;
        end else begin
            load_q   <= load_n;
            signed_q <= signed_n;
            multi_q  <= multi_n;
            size_q   <= size_n;
            mask_q   <= mask_n;
            cur_q    <= cur_n;
            addr_q   <= addr_n;
            cnt_q    <= cnt_n;
            wait_q   <= wait_n;
            ready_q  <= ready_n;
            rd_q     <= rd_n;
            wr_q     <= wr_n;
            maddr_q  <= maddr_n;
            width_q  <= width_n;
            done_q   <= done_n;
            derr_q   <= derr_n;
            daddr_q  <= daddr_n;
            dcnt_q   <= dcnt_n;
        end
    end

    // load data: ARM rotation for single word loads, zero/sign extension for byte and half
    always_comb begin
        rot_sh   = {1'b0, addr_q[1:0], 3'b000};
        rot_word = 32'({bus.mem_rdata, bus.mem_rdata} >> rot_sh);
        unique case (size_q)
            SZ_BYTE: load_data = {{24{signed_q & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
            SZ_HALF: load_data = {{16{signed_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            default: load_data = multi_q ? bus.mem_rdata : rot_word;
        endcase
    end

    assign bus.req_ready  = ready_q;
    assign bus.rf_raddr   = cur_q;
    assign bus.rf_waddr   = cur_q;
    assign bus.rf_we      = (state_q == ACCESS) && load_q && bus.mem_ok;
    assign bus.rf_wdata   = load_data;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = bus.rf_rdata;
    assign bus.mem_width  = width_q;
    assign bus.mem_read   = rd_q;
    assign bus.mem_write  = wr_q;
    assign bus.done       = done_q;
    assign bus.done_err   = derr_q;
    assign bus.done_addr  = daddr_q;
    assign bus.done_count = dcnt_q;
endmodule

// File: tb/tb_lsu_multi.sv
// Scoreboard bench for lsu_multi: tasks queue expected beats, writebacks and completions;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_lsu_multi;
    localparam logic [31:0] K = 32'h5A5A_5A5A;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic        rd;
        logic        wr;
    } beat_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [4:0]  count;
    } done_t;

    logic clk;
    logic rstn;

    beat_t exp_beat[$];
    wr_t   exp_wr[$];
    done_t exp_done[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] regs [16];

    // memory responder configuration and state
    int          ok_delay   = 0;
    int          ok_limit   = 1000;
    int          resp_beats = 0;
    int          rwait      = 0;
    bit          prev_s     = 0;
    bit          prev_ok    = 0;
    bit          use_fixed  = 0;
    logic [31:0] fixed_rdata = '0;

    lsu_multi_if #(.NREGS(16), .ADDR_W(32)) bus ();

    lsu_multi #(.NREGS(16), .ADDR_W(32), .WAIT_MAX(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rf_rdata = regs[bus.rf_raddr];

    // memory: mem_ok after ok_delay waiting cycles per beat, at most ok_limit beats
    always @(posedge clk) begin
        bit s;
        bit ok;
        #1;
        if (prev_s && prev_ok) begin
            resp_beats++;
            rwait = 0;
        end else if (prev_s) begin
            rwait++;
        end
        s = bus.mem_read | bus.mem_write;
        if (!s) rwait = 0;
        ok = s && (resp_beats < ok_limit) && (rwait >= ok_delay);
        bus.mem_ok    = ok;
        bus.mem_rdata = use_fixed ? fixed_rdata : (bus.mem_addr ^ K);
        prev_s  = s;
        prev_ok = ok;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        beat_t ob, eb;
        wr_t   ow, ew;
        done_t od, ed;
        if ((bus.mem_read || bus.mem_write) && bus.mem_ok) begin
            ob.addr  = bus.mem_addr;
            ob.wdata = bus.mem_write ? bus.mem_wdata : 32'h0;
            ob.width = bus.mem_width;
            ob.rd    = bus.mem_read;
            ob.wr    = bus.mem_write;
            n_checks++;
            if (exp_beat.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got addr=%h wdata=%h width=%0d rd=%b wr=%b, required none",
                         ob.addr, ob.wdata, ob.width, ob.rd, ob.wr);
            end else begin
                eb = exp_beat.pop_front();
                if (ob !== eb) begin
                    n_fail++;
                    $display("FAIL beat: got addr=%h wdata=%h width=%0d rd=%b wr=%b, required addr=%h wdata=%h width=%0d rd=%b wr=%b",
                             ob.addr, ob.wdata, ob.width, ob.rd, ob.wr, eb.addr, eb.wdata, eb.width, eb.rd, eb.wr);
                end
            end
        end
        if (bus.rf_we) begin
            ow.idx  = bus.rf_waddr;
            ow.data = bus.rf_wdata;
            n_checks++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL rf_we_unexpected: got idx=%0d data=%h, required none", ow.idx, ow.data);
            end else begin
                ew = exp_wr.pop_front();
                if (ow !== ew) begin
                    n_fail++;
                    $display("FAIL writeback: got idx=%0d data=%h, required idx=%0d data=%h",
                             ow.idx, ow.data, ew.idx, ew.data);
                end
            end
        end
        if (bus.done) begin
            od.err   = bus.done_err;
            od.addr  = bus.done_addr;
            od.count = bus.done_count;
            n_checks++;
            if (exp_done.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got err=%b addr=%h count=%0d, required none", od.err, od.addr, od.count);
            end else begin
                ed = exp_done.pop_front();
                if (od !== ed) begin
                    n_fail++;
                    $display("FAIL done: got err=%b addr=%h count=%0d, required err=%b addr=%h count=%0d",
                             od.err, od.addr, od.count, ed.err, ed.addr, ed.count);
                end
            end
        end
    end

    task automatic drive_req(input bit load, input logic [1:0] size, input bit sgn, input bit multi,
                             input logic [15:0] mask, input logic [31:0] addr);
        bus.req_load    = load;
        bus.req_size    = size;
        bus.req_signed  = sgn;
        bus.req_multi   = multi;
        bus.req_regmask = mask;
        bus.req_addr    = addr;
        bus.req_valid   = 1'b1;
        @(posedge clk); #2;
        bus.req_valid   = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        for (int i = 0; i < 60; i++) begin
            if (bus.req_ready) break;
            @(posedge clk); #2;
        end
        ok = bus.req_ready;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.req_ready); end
        n_checks++;
        if ({bus.mem_read, bus.mem_write, bus.rf_we} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b required 000", {bus.mem_read, bus.mem_write, bus.rf_we});
        end
        n_checks++;
        if ({bus.done, bus.done_err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_done: got %b required 00", {bus.done, bus.done_err});
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0 || bus.done_addr !== 32'h0 || bus.done_count !== 5'h0) begin
            n_fail++; $display("FAIL reset_addr: got mem_addr=%h done_addr=%h count=%0d required 0",
                               bus.mem_addr, bus.done_addr, bus.done_count);
        end
        rstn = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", bus.req_ready); end
    endtask

    task automatic test_single_word;
        use_fixed = 1; fixed_rdata = 32'hAABB_CCDD; ok_delay = 0; resp_beats = 0;
        exp_beat.push_back('{addr: 32'h0800_0000, wdata: 32'h0, width: 2'd2, rd: 1'b1, wr: 1'b0});
        exp_wr.push_back('{idx: 4'd0, data: 32'hCCDD_AABB});
        exp_done.push_back('{err: 1'b0, addr: 32'h0800_0002, count: 5'd1});
        drive_req(1'b1, 2'd2, 1'b0, 1'b0, 16'h0001, 32'h0800_0002);
        @(posedge clk); #2;
        n_checks++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL single_done_latency: got done=%b required 1", bus.done); end
        @(posedge clk); #2;
        n_checks++;
        if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_after_done: got done=%b ready=%b required 0 1", bus.done, bus.req_ready);
        end
        n_checks++;
        if (exp_beat.size() + exp_wr.size() + exp_done.size() != 0) begin
            n_fail++; $display("FAIL single_pending: got %0d outstanding required 0", exp_beat.size() + exp_wr.size() + exp_done.size());
        end
    endtask

    task automatic test_sign_ext;
        logic [1:0]  sz   [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2};
        bit          sg   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ad   [7] = '{32'h0300_0001, 32'h0300_0002, 32'h0300_0002, 32'h0300_0003,
                                  32'h0A00_0001, 32'h0300_0001, 32'h0300_0000};
        logic [31:0] rdt  [7] = '{32'h0000_0080, 32'h0000_8001, 32'h0000_8001, 32'h0000_FF7F,
                                  32'h1122_3344, 32'h0000_0080, 32'h8000_0000};
        logic [15:0] msk  [7] = '{16'h0030, 16'h0001, 16'h8000, 16'h0004, 16'h0202, 16'h0001, 16'h0001};
        logic [31:0] eadr [7] = '{32'h0300_0001, 32'h0300_0002, 32'h0300_0002, 32'h0300_0002,
                                  32'h0A00_0000, 32'h0300_0001, 32'h0300_0000};
        logic [1:0]  ewid [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2};
        logic [31:0] edat [7] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_FF7F,
                                  32'h4411_2233, 32'h0000_0080, 32'h8000_0000};
        logic [3:0]  eidx [7] = '{4'd4, 4'd0, 4'd15, 4'd2, 4'd1, 4'd0, 4'd0};
        bit ok;
        use_fixed = 1; ok_delay = 0;
        for (int i = 0; i < 7; i++) begin
            fixed_rdata = rdt[i];
            exp_beat.push_back('{addr: eadr[i], wdata: 32'h0, width: ewid[i], rd: 1'b1, wr: 1'b0});
            exp_wr.push_back('{idx: eidx[i], data: edat[i]});
            exp_done.push_back('{err: 1'b0, addr: ad[i], count: 5'd1});
            drive_req(1'b1, sz[i], sg[i], 1'b0, msk[i], ad[i]);
            wait_ready(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL ext_timeout case %0d: got ready=0 required 1", i); end
        end
        n_checks++;
        if (exp_beat.size() + exp_wr.size() + exp_done.size() != 0) begin
            n_fail++; $display("FAIL ext_pending: got %0d outstanding required 0", exp_beat.size() + exp_wr.size() + exp_done.size());
        end
    endtask

    task automatic test_ldm;
        logic [31:0] a [3] = '{32'h0300_0010, 32'h0300_0014, 32'h0300_0018};
        logic [3:0]  r [3] = '{4'd0, 4'd1, 4'd3};
        bit ok;
        use_fixed = 0; ok_delay = 0;
        for (int i = 0; i < 3; i++) begin
            exp_beat.push_back('{addr: a[i], wdata: 32'h0, width: 2'd2, rd: 1'b1, wr: 1'b0});
            exp_wr.push_back('{idx: r[i], data: a[i] ^ K});
        end
        exp_done.push_back('{err: 1'b0, addr: 32'h0300_001C, count: 5'd3});
        drive_req(1'b1, 2'd0, 1'b1, 1'b1, 16'h000B, 32'h0300_0010);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.mem_read !== 1'b1 || bus.mem_addr !== a[i]) begin
                n_fail++; $display("FAIL ldm_streaming beat %0d: got read=%b addr=%h required 1 %h", i, bus.mem_read, bus.mem_addr, a[i]);
            end
            @(posedge clk); #2;
        end
        n_checks++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ldm_done_cycle: got done=%b required 1", bus.done); end
        wait_ready(ok);
        n_checks++;
        if (!ok || exp_beat.size() + exp_wr.size() + exp_done.size() != 0) begin
            n_fail++; $display("FAIL ldm_pending: got ready=%b outstanding=%0d required 1 0", ok, exp_beat.size() + exp_wr.size() + exp_done.size());
        end
    endtask

    task automatic test_stm_wait;
        bit          prev_w = 0;
        logic [31:0] prev_a = '0;
        int          prev_b = 0;
        use_fixed = 0; ok_delay = 2; resp_beats = 0;
        exp_beat.push_back('{addr: 32'h0400_0020, wdata: regs[1], width: 2'd2, rd: 1'b0, wr: 1'b1});
        exp_beat.push_back('{addr: 32'h0400_0024, wdata: regs[2], width: 2'd2, rd: 1'b0, wr: 1'b1});
        exp_done.push_back('{err: 1'b0, addr: 32'h0400_0028, count: 5'd2});
        drive_req(1'b0, 2'd2, 1'b0, 1'b1, 16'h0006, 32'h0400_0020);
        for (int i = 0; i < 40; i++) begin
            if (prev_w && resp_beats == prev_b) begin
                n_checks++;
                if (bus.mem_write !== 1'b1 || bus.mem_addr !== prev_a) begin
                    n_fail++; $display("FAIL stm_hold: got write=%b addr=%h required 1 %h", bus.mem_write, bus.mem_addr, prev_a);
                end
            end
            prev_w = bus.mem_write;
            prev_a = bus.mem_addr;
            prev_b = resp_beats;
            if (bus.req_ready) break;
            @(posedge clk); #2;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1 || exp_beat.size() + exp_done.size() != 0) begin
            n_fail++; $display("FAIL stm_pending: got ready=%b outstanding=%0d required 1 0", bus.req_ready, exp_beat.size() + exp_done.size());
        end
        ok_delay = 0;
    endtask

    task automatic test_timeout;
        bit ok;
        use_fixed = 0; ok_delay = 0; ok_limit = 1; resp_beats = 0;
        exp_beat.push_back('{addr: 32'h0500_0040, wdata: 32'h0, width: 2'd2, rd: 1'b1, wr: 1'b0});
        exp_wr.push_back('{idx: 4'd0, data: 32'h0500_0040 ^ K});
        exp_done.push_back('{err: 1'b1, addr: 32'h0500_0044, count: 5'd1});
        drive_req(1'b1, 2'd2, 1'b0, 1'b1, 16'h0003, 32'h0500_0040);
        wait_ready(ok);
        n_checks++;
        if (!ok || exp_beat.size() + exp_wr.size() + exp_done.size() != 0) begin
            n_fail++; $display("FAIL timeout_pending: got ready=%b outstanding=%0d required 1 0", ok, exp_beat.size() + exp_wr.size() + exp_done.size());
        end
        ok_limit = 1000;
    endtask

    task automatic test_reset_mid;
        bit seen_done = 0;
        use_fixed = 0; ok_delay = 2; resp_beats = 0;
        exp_beat.push_back('{addr: 32'h0300_0100, wdata: 32'h0, width: 2'd2, rd: 1'b1, wr: 1'b0});
        exp_wr.push_back('{idx: 4'd0, data: 32'h0300_0100 ^ K});
        drive_req(1'b1, 2'd2, 1'b0, 1'b1, 16'h0007, 32'h0300_0100);
        for (int i = 0; i < 20 && resp_beats < 1; i++) begin
            @(posedge clk); #2;
        end
        n_checks++;
        if (resp_beats != 1 || bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0300_0104) begin
            n_fail++; $display("FAIL rstmid_second_beat: got beats=%0d read=%b addr=%h required 1 1 03000104",
                               resp_beats, bus.mem_read, bus.mem_addr);
        end
        rstn = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if (bus.mem_read !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_abandon: got read=%b done=%b required 0 0", bus.mem_read, bus.done);
        end
        @(posedge clk); #2;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            if (bus.done) seen_done = 1;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1 || seen_done) begin
            n_fail++; $display("FAIL rstmid_after: got ready=%b done_seen=%b required 1 0", bus.req_ready, seen_done);
        end
        n_checks++;
        if (exp_beat.size() + exp_wr.size() + exp_done.size() != 0) begin
            n_fail++; $display("FAIL rstmid_pending: got %0d outstanding required 0", exp_beat.size() + exp_wr.size() + exp_done.size());
        end
        ok_delay = 0;
    endtask

    task automatic test_empty_mask;
        int b0;
        b0 = resp_beats;
        exp_done.push_back('{err: 1'b0, addr: 32'h0600_0000, count: 5'd0});
        drive_req(1'b1, 2'd2, 1'b0, 1'b1, 16'h0000, 32'h0600_0000);
        n_checks++;
        if (bus.done !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            n_fail++; $display("FAIL empty_done: got done=%b read=%b write=%b required 1 0 0", bus.done, bus.mem_read, bus.mem_write);
        end
        @(posedge clk); #2;
        n_checks++;
        if (bus.req_ready !== 1'b1 || resp_beats != b0 || exp_done.size() != 0) begin
            n_fail++; $display("FAIL empty_after: got ready=%b beats=%0d pending=%0d required 1 %0d 0",
                               bus.req_ready, resp_beats, exp_done.size(), b0);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        use_fixed = 0; ok_delay = 2;
        exp_beat.push_back('{addr: 32'h0700_0003, wdata: regs[8], width: 2'd0, rd: 1'b0, wr: 1'b1});
        exp_done.push_back('{err: 1'b0, addr: 32'h0700_0003, count: 5'd1});
        drive_req(1'b0, 2'd0, 1'b0, 1'b0, 16'h0100, 32'h0700_0003);
        // a request while busy must be ignored
        drive_req(1'b1, 2'd2, 1'b0, 1'b1, 16'hFFFF, 32'h0900_0000);
        wait_ready(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_first_ready: got 0 required 1"); end
        ok_delay = 0;
        exp_beat.push_back('{addr: 32'h0700_0010, wdata: regs[3], width: 2'd2, rd: 1'b0, wr: 1'b1});
        exp_done.push_back('{err: 1'b0, addr: 32'h0700_0010, count: 5'd1});
        drive_req(1'b0, 2'd2, 1'b0, 1'b0, 16'h0008, 32'h0700_0010);
        wait_ready(ok);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (!ok || exp_beat.size() + exp_wr.size() + exp_done.size() != 0) begin
            n_fail++; $display("FAIL b2b_pending: got ready=%b outstanding=%0d required 1 0", ok, exp_beat.size() + exp_wr.size() + exp_done.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'hC0DE_0000 + 32'(i) * 32'h0001_1111;
        rstn            = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_load    = 1'b0;
        bus.req_size    = 2'd0;
        bus.req_signed  = 1'b0;
        bus.req_multi   = 1'b0;
        bus.req_regmask = '0;
        bus.req_addr    = '0;
        bus.mem_ok      = 1'b0;
        bus.mem_rdata   = '0;
        test_reset();
        test_single_word();
        test_sign_ext();
        test_ldm();
        test_stm_wait();
        test_timeout();
        test_reset_mid();
        test_empty_mask();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
